mul_add_check: RTL and testbench

Sequential shift-add multiply-accumulate unit that computes Prod = A*B + R. It is the inverse of the team's restoring divider: it rebuilds a dividend from a quotient, divisor and remainder. It sits beside the divider as a self-check path and also serves as a general multi-cycle multiplier. It takes one operand set per start handshake and always returns its result after a fixed latency.

---
 rtl/mul_add_check.sv | 97 +++++++++
 tb/tb_mul_add_check.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_add_check.sv
// Sequential shift-add multiply-accumulate: Prod = A*B + R after a fixed WIDTH-cycle run.
// Rebuilds a dividend from quotient/divisor/remainder; also usable as a plain multiplier.
module mul_add_check #(
   parameter int unsigned WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [WIDTH-1:0]   R,
   output logic [2*WIDTH-1:0] Prod,
   output logic               Ovf,
   output logic               busy,
   output logic               done
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   prod_q, prod_d;
   logic                 ovf_q, ovf_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         ovf_q    <= ovf_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      ovf_d    = ovf_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               mcand_d  = {{WIDTH{1'b0}}, A};
               mplier_d = B;
               acc_d    = {{WIDTH{1'b0}}, R};
               cnt_d    = '0;
               state_d  = StRun;
            end
         end
         StRun: begin
            // Always WIDTH iterations, even once mplier is zero, to keep latency fixed.
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CntW'(1);
            if (cnt_q == CntW'(WIDTH - 1)) begin
               prod_d  = acc_d;
               ovf_d   = |acc_d[2*WIDTH-1:WIDTH];
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign Prod = prod_q;
   assign Ovf  = ovf_q;
   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);

endmodule

// File: tb/tb_mul_add_check.sv
// Self-checking bench for mul_add_check: vector table, random reference-model checks,
// and hand-written sequences for ignored starts, mid-run reset and back-to-back issue.
module tb_mul_add_check;

   localparam int unsigned W = 16;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a_in, b_in, r_in;
   logic [2*W-1:0] prod;
   logic           ovf, busy, done;

   int n_cmp;
   int n_fail;

   mul_add_check #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (a_in),
      .B     (b_in),
      .R     (r_in),
      .Prod  (prod),
      .Ovf   (ovf),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [W-1:0]   r;
      logic [2*W-1:0] exp_prod;
      logic           exp_ovf;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one operation and wait (bounded) for its done pulse.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r,
                         output logic [2*W-1:0] res, output logic res_ovf, output int lat);
      @(negedge clk);
      a_in  = a;
      b_in  = b;
      r_in  = r;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      r_in  = W'($urandom);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      res     = prod;
      res_ovf = ovf;
      if (!done) check("done_timeout", 64'(done), 64'd1);
      @(negedge clk);
   endtask

   // Reference: plain arithmetic on wide integers.
   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] r);
      longint unsigned v;
      v = longint'(a) * longint'(b) + longint'(r);
      return v[2*W-1:0];
   endfunction

   vec_t           vecs[$];
   logic [2*W-1:0] res;
   logic           res_ovf;
   int             lat;

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      start  = 1'b0;
      a_in   = '0;
      b_in   = '0;
      r_in   = '0;
      rst_n  = 1'b0;

      vecs.push_back('{a:16'd7,    b:16'd3,      r:16'd2,      exp_prod:32'd23,        exp_ovf:1'b0});
      vecs.push_back('{a:16'hFFFF, b:16'hFFFF,   r:16'hFFFF,   exp_prod:32'hFFFF0000,  exp_ovf:1'b1});
      vecs.push_back('{a:16'd0,    b:16'h1234,   r:16'd0,      exp_prod:32'd0,         exp_ovf:1'b0});
      vecs.push_back('{a:16'd1,    b:16'd1,      r:16'd0,      exp_prod:32'd1,         exp_ovf:1'b0});
      vecs.push_back('{a:16'h1234, b:16'd0,      r:16'hFFFF,   exp_prod:32'h0000FFFF,  exp_ovf:1'b0});
      vecs.push_back('{a:16'hFFFF, b:16'd1,      r:16'd0,      exp_prod:32'h0000FFFF,  exp_ovf:1'b0});
      vecs.push_back('{a:16'h0100, b:16'h0100,   r:16'd0,      exp_prod:32'h00010000,  exp_ovf:1'b1});
      vecs.push_back('{a:16'h00FF, b:16'h00FF,   r:16'h01FE,   exp_prod:32'h0000FFFF,  exp_ovf:1'b0});
      vecs.push_back('{a:16'h8000, b:16'h0002,   r:16'd0,      exp_prod:32'h00010000,  exp_ovf:1'b1});

      repeat (3) @(negedge clk);
      check("reset_prod", 64'(prod), 64'd0);
      check("reset_ovf",  64'(ovf),  64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // First operation also checks the accept/done/busy timing.
      @(negedge clk);
      a_in = 16'd7; b_in = 16'd3; r_in = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", 64'(busy), 64'd1);
      lat = 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat < W) check("done_early", 64'(done), 64'd0);
      end
      check("latency", 64'(lat), 64'(W));
      check("first_prod", 64'(prod), 64'd23);
      check("first_ovf",  64'(ovf),  64'd0);
      check("busy_in_done", 64'(busy), 64'd1);
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
      check("busy_falls", 64'(busy), 64'd0);

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].r, res, res_ovf, lat);
         check($sformatf("vec%0d_prod", i), 64'(res), 64'(vecs[i].exp_prod));
         check($sformatf("vec%0d_ovf", i),  64'(res_ovf), 64'(vecs[i].exp_ovf));
         check($sformatf("vec%0d_lat", i),  64'(lat), 64'(W));
      end

      // Divider round-trip: quotient*divisor + remainder rebuilds the dividend.
      for (int i = 0; i < 500; i++) begin
         logic [W-1:0] dvd, dvs, q, r;
         dvd = W'($urandom);
         dvs = W'($urandom_range(65535, 1));
         q   = dvd / dvs;
         r   = dvd % dvs;
         run_op(q, dvs, r, res, res_ovf, lat);
         check($sformatf("rt%0d_prod", i), 64'(res), 64'(dvd));
         check($sformatf("rt%0d_ovf", i),  64'(res_ovf), 64'd0);
      end

      // General random operands.
      for (int i = 0; i < 100; i++) begin
         logic [W-1:0]   ra, rb, rr;
         logic [2*W-1:0] e;
         ra = W'($urandom);
         rb = W'($urandom);
         rr = W'($urandom);
         e  = ref_prod(ra, rb, rr);
         run_op(ra, rb, rr, res, res_ovf, lat);
         check($sformatf("rnd%0d_prod", i), 64'(res), 64'(e));
         check($sformatf("rnd%0d_ovf", i),  64'(res_ovf), 64'(e[2*W-1:W] != 0));
      end

      // Starts at edges T3 and T(W+1) of a busy operation must be ignored.
      begin
         int n_done;
         int done_at;
         logic [2*W-1:0] got;
         n_done  = 0;
         done_at = -1;
         got     = '0;
         @(negedge clk);
         a_in = 16'd10; b_in = 16'd20; r_in = 16'd5; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int k = 0; k < W + 6; k++) begin
            start = ((k + 1) == 3) || ((k + 1) == W + 1);
            a_in  = W'($urandom);
            b_in  = W'($urandom);
            r_in  = W'($urandom);
            @(negedge clk);
            if (done) begin
               n_done++;
               done_at = k + 1;
               got     = prod;
            end
         end
         start = 1'b0;
         check("ign_done_count", 64'(n_done), 64'd1);
         check("ign_done_edge",  64'(done_at), 64'(W));
         check("ign_prod", 64'(got), 64'd205);
         check("ign_prod_held", 64'(prod), 64'd205);
         check("ign_idle", 64'(busy), 64'd0);
      end

      // Reset at cycle 8 of RUN discards the operation.
      begin
         int n_done;
         n_done = 0;
         @(negedge clk);
         a_in = 16'd300; b_in = 16'd400; r_in = 16'd1; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (8) begin
            @(negedge clk);
            if (done) n_done++;
         end
         rst_n = 1'b0;
         #1;
         check("rst_prod", 64'(prod), 64'd0);
         check("rst_ovf",  64'(ovf),  64'd0);
         check("rst_busy", 64'(busy), 64'd0);
         check("rst_done", 64'(done), 64'd0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (W + 4) begin
            @(negedge clk);
            if (done) n_done++;
         end
         check("rst_no_done", 64'(n_done), 64'd0);
         check("rst_idle", 64'(busy), 64'd0);
         run_op(16'd5, 16'd5, 16'd0, res, res_ovf, lat);
         check("post_rst_prod", 64'(res), 64'd25);
         check("post_rst_ovf",  64'(res_ovf), 64'd0);
      end

      // start held high: accepts every W+2 cycles, each result matches its operands.
      begin
         logic [W-1:0] oa[3];
         logic [W-1:0] ob[3];
         logic [W-1:0] orr[3];
         int acc_cyc[3];
         int cyc, n_acc, n_done;
         logic prev_busy;
         for (int i = 0; i < 3; i++) begin
            oa[i]  = W'($urandom);
            ob[i]  = W'($urandom);
            orr[i] = W'($urandom);
            acc_cyc[i] = 0;
         end
         cyc = 0; n_acc = 0; n_done = 0;
         @(negedge clk);
         prev_busy = busy;
         a_in = oa[0]; b_in = ob[0]; r_in = orr[0]; start = 1'b1;
         while (n_done < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (busy && !prev_busy) begin
               if (n_acc < 3) acc_cyc[n_acc] = cyc;
               n_acc++;
               if (n_acc < 3) begin
                  a_in = oa[n_acc]; b_in = ob[n_acc]; r_in = orr[n_acc];
               end
            end
            if (done) begin
               check($sformatf("b2b%0d_prod", n_done), 64'(prod),
                     64'(ref_prod(oa[n_done], ob[n_done], orr[n_done])));
               n_done++;
               if (n_done == 3) start = 1'b0;
            end
            prev_busy = busy;
         end
         start = 1'b0;
         check("b2b_done_count", 64'(n_done), 64'd3);
         check("b2b_acc_count",  64'(n_acc),  64'd3);
         check("b2b_interval1", 64'(acc_cyc[1] - acc_cyc[0]), 64'(W + 2));
         check("b2b_interval2", 64'(acc_cyc[2] - acc_cyc[1]), 64'(W + 2));
         repeat (3) @(negedge clk);
         check("b2b_idle", 64'(busy), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
